mmio_ctrl: RTL and testbench
============================

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter: RX_DEPTH, 4, RX byte FIFO entries (power of two, >=2).
REQ-002 Parameter: MMIO_BASE, 32'h8000_0000, base of the I/O address window.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_addr  input  32  byte address of the load/store issued by the memory stage.
REQ-006 req_re  input  1  load request this cycle.
REQ-007 req_we  input  1  store request this cycle (req_re and req_we never both high).
REQ-008 req_wdata  input  32  store data, byte 0 in [7:0].
REQ-009 inst_retire  input  1  one instruction retired this cycle.
REQ-010 rdata  output  32  load result, valid the cycle after req_re.
REQ-011 uart_rx_data_out  input  8  received byte from UART.
REQ-012 uart_rx_data_out_valid  input  1  received byte valid.
REQ-013 uart_rx_data_out_ready  output  1  block accepts received byte.
REQ-014 uart_tx_data_in  output  8  byte to transmit.
REQ-015 uart_tx_data_in_valid  output  1  transmit byte valid.
REQ-016 uart_tx_data_in_ready  input  1  UART transmitter accepts byte.

Function
REQ-017 Address map (offsets from MMIO_BASE): 0x00 status R, 0x04 rx data R, 0x08 tx data W, 0x10 cycle counter R, 0x14 retired-instruction counter R, 0x18 counter clear W.
REQ-018 Decode uses full 32-bit address equality; unmapped addresses: loads return 0, stores ignored.
REQ-019 rdata is registered: value for a load in cycle N appears in cycle N+1 and holds until the next load; non-MMIO loads yield 0.
REQ-020 Status word: bit0 = tx_ready, bit1 = rx_valid, bits[31:2] = 0.
REQ-021 rx_valid = FIFO count != 0; tx_ready = !tx_pending && uart_tx_data_in_ready.
REQ-022 RX FIFO push when uart_rx_data_out_valid && uart_rx_data_out_ready; uart_rx_data_out_ready = count != RX_DEPTH.
REQ-023 Load of 0x04 with FIFO non-empty returns {24'b0, head byte} and pops in the same cycle; with FIFO empty returns 0, no pop.
REQ-024 Simultaneous push and pop: count unchanged, FIFO order preserved; pointers wrap modulo RX_DEPTH.
REQ-025 Store to 0x08 with tx_pending low: latch req_wdata[7:0], set tx_pending next cycle.
REQ-026 uart_tx_data_in_valid = tx_pending; uart_tx_data_in holds latched byte while pending.
REQ-027 tx_pending clears in the cycle after valid && ready handshake.
REQ-028 Store to 0x08 while tx_pending high: dropped, latched byte unchanged.
REQ-029 Cycle counter increments by 1 every non-reset cycle; retired counter increments when inst_retire; both wrap 2^32-1 -> 0.
REQ-030 Store to 0x18 (any data): both counters read 0 in the following cycle; clear overrides same-cycle increment.
REQ-031 Loads of counters return the pre-update value of the request cycle.

Reset
REQ-032 While rst high: FIFO empty, pointers 0, tx_pending 0, counters 0, rdata 0, uart_tx_data_in 0.
REQ-033 rst high mid-transfer: pending TX byte and buffered RX bytes discarded; uart_rx_data_out_ready = 1 and uart_tx_data_in_valid = 0 in first cycle after reset.
REQ-034 Requests presented while rst high have no effect.

Verification
REQ-035 Push 0x41,0x42 via RX; load 0x80000004 twice -> rdata 0x41 then 0x42; status bit1 then 0.
REQ-036 Push 5 bytes with RX_DEPTH=4, no loads -> ready low after 4th, 5th not accepted; drain returns first 4 in order.
REQ-037 Store 0x55 to 0x80000008, ready low 3 cycles -> valid held, byte 0x55 stable; second store 0x66 dropped; ready high -> one handshake, status bit0 returns 1.
REQ-038 Run 100 cycles, 37 retire pulses, load 0x10 and 0x14 -> 100 and 37 (counted from reset release); store 0x18 -> next-cycle loads return 0.
REQ-039 Force cycle counter to 0xFFFFFFFF -> next cycle reads 0.
REQ-040 Assert rst with 3 RX bytes and TX pending -> status reads 0x1 with UART ready, rx load returns 0.

Source files
------------

// File: rtl/mmio_ctrl_if.sv
// Bus bundle between the memory stage / UART and the MMIO controller.
// The master side drives requests and UART inputs; the slave side is mmio_ctrl.
interface mmio_ctrl_if;
  logic [31:0] req_addr;
  logic        req_re;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  uart_rx_data_out;
  logic        uart_rx_data_out_valid;
  logic        uart_rx_data_out_ready;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_in_valid;
  logic        uart_tx_data_in_ready;

  modport master (
    output req_addr, req_re, req_we, req_wdata, inst_retire,
    output uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
    input  rdata, uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
  );

  modport slave (
    input  req_addr, req_re, req_we, req_wdata, inst_retire,
    input  uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
    output rdata, uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
  );
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: UART status/RX/TX registers plus free-running
// cycle and retired-instruction counters behind a small fixed address window.
module mmio_ctrl #(
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input logic        clk,
  input logic        rst,
  mmio_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  localparam logic [31:0] ADDR_STATUS = MMIO_BASE + 32'h00;
  localparam logic [31:0] ADDR_RXDATA = MMIO_BASE + 32'h04;
  localparam logic [31:0] ADDR_TXDATA = MMIO_BASE + 32'h08;
  localparam logic [31:0] ADDR_CYCLE  = MMIO_BASE + 32'h10;
  localparam logic [31:0] ADDR_RETIRE = MMIO_BASE + 32'h14;
  localparam logic [31:0] ADDR_CLEAR  = MMIO_BASE + 32'h18;

  localparam logic [PTR_W:0]   RX_FULL = (PTR_W+1)'(RX_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr;
  logic [PTR_W-1:0] rx_rd_ptr;
  logic [PTR_W:0]   rx_count;

  logic             tx_pending;
  logic [7:0]       tx_byte;

  logic [31:0]      cycle_cnt;
  logic [31:0]      retire_cnt;
  logic [31:0]      rdata_q;
  logic [31:0]      load_data;

  logic hit_status, hit_rxdata, hit_txdata, hit_cycle, hit_retire, hit_clear;
  logic rx_valid, rx_ready, tx_ready;
  logic rx_push, rx_pop, tx_store, tx_done, cnt_clear;
  logic wdata_unused;

  // Exact 32-bit address decode; anything else falls through as unmapped.
  assign hit_status = (bus.req_addr == ADDR_STATUS);
  assign hit_rxdata = (bus.req_addr == ADDR_RXDATA);
  assign hit_txdata = (bus.req_addr == ADDR_TXDATA);
  assign hit_cycle  = (bus.req_addr == ADDR_CYCLE);
  assign hit_retire = (bus.req_addr == ADDR_RETIRE);
  assign hit_clear  = (bus.req_addr == ADDR_CLEAR);

  assign rx_valid = (rx_count != '0);
  assign rx_ready = (rx_count != RX_FULL);
  assign tx_ready = !tx_pending && bus.uart_tx_data_in_ready;

  assign rx_push   = bus.uart_rx_data_out_valid && rx_ready;
  assign rx_pop    = bus.req_re && hit_rxdata && rx_valid;
  assign tx_store  = bus.req_we && hit_txdata && !tx_pending;
  assign tx_done   = tx_pending && bus.uart_tx_data_in_ready;
  assign cnt_clear = bus.req_we && hit_clear;

  assign wdata_unused = ^bus.req_wdata[31:8];

  assign bus.rdata                  = rdata_q;
  assign bus.uart_rx_data_out_ready = rx_ready;
  assign bus.uart_tx_data_in_valid  = tx_pending;
  assign bus.uart_tx_data_in        = tx_byte;

  // Select the value a load would return this cycle; write-only and unmapped read as zero.
  always_comb begin
    load_data = '0;
    if (hit_status) begin
      load_data = {30'b0, rx_valid, tx_ready};
    end else if (hit_rxdata) begin
      load_data = rx_valid ? {24'b0, rx_mem[rx_rd_ptr]} : 32'b0;
    end else if (hit_cycle) begin
      load_data = cycle_cnt;
    end else if (hit_retire) begin
      load_data = retire_cnt;
    end
  end

  // Registered load result, held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (bus.req_re) begin
      rdata_q <= load_data;
    end
  end

  // RX FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (!rst && rx_push) begin
      rx_mem[rx_wr_ptr] <= bus.uart_rx_data_out;
    end
  end

  // RX FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      end
      if (rx_push && !rx_pop) begin
        rx_count <= rx_count + CNT_ONE;
      end else if (rx_pop && !rx_push) begin
        rx_count <= rx_count - CNT_ONE;
      end
    end
  end

  // Single-entry TX holding register; stores while busy are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pending <= 1'b0;
      tx_byte    <= '0;
    end else if (tx_store) begin
      tx_byte    <= bus.req_wdata[7:0];
      tx_pending <= 1'b1;
    end else if (tx_done) begin
      tx_pending <= 1'b0;
    end
  end

  // Performance counters; a clear store wins over the same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (cnt_clear) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      retire_cnt <= retire_cnt + {31'b0, bus.inst_retire};
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl with a reference model and load/TX scoreboards.
module tb_mmio_ctrl;

  localparam int unsigned  RX_DEPTH = 4;
  localparam logic [31:0]  BASE     = 32'h8000_0000;
  localparam logic [31:0]  A_STATUS = BASE + 32'h00;
  localparam logic [31:0]  A_RX     = BASE + 32'h04;
  localparam logic [31:0]  A_TX     = BASE + 32'h08;
  localparam logic [31:0]  A_CYC    = BASE + 32'h10;
  localparam logic [31:0]  A_RET    = BASE + 32'h14;
  localparam logic [31:0]  A_CLR    = BASE + 32'h18;

  logic clk;
  logic rst;
  mmio_ctrl_if bus ();

  mmio_ctrl #(.RX_DEPTH(RX_DEPTH), .MMIO_BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_rxq [$];
  logic [31:0] exp_q [$];
  logic [7:0]  tx_q  [$];
  bit          m_txp;
  logic [7:0]  m_txb;
  logic [31:0] m_cyc;
  logic [31:0] m_ret;
  logic [31:0] m_rdata;
  bit          model_valid = 0;
  bit          tx_rdy = 1;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, check state outputs, update the model, check rdata after the edge.
  task automatic applyStimulus(input bit r, input bit re, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, input bit retire, input bit rxv,
                               input logic [7:0] rxd, input bit txr);
    logic [31:0] exp_val;
    bit pop_ok;
    bit push_ok;
    logic [7:0] got;
    @(negedge clk);
    rst = r;
    bus.req_re = re;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.inst_retire = retire;
    bus.uart_rx_data_out_valid = rxv;
    bus.uart_rx_data_out = rxd;
    bus.uart_tx_data_in_ready = txr;
    #1;
    if (model_valid) begin
      checkOutput("rx_ready", {31'b0, bus.uart_rx_data_out_ready}, {31'b0, (m_rxq.size() != RX_DEPTH)});
      checkOutput("tx_valid", {31'b0, bus.uart_tx_data_in_valid}, {31'b0, m_txp});
      if (m_txp) checkOutput("tx_byte_hold", {24'b0, bus.uart_tx_data_in}, {24'b0, m_txb});
    end
    if (r) begin
      m_rxq.delete();
      exp_q.delete();
      tx_q.delete();
      m_txp = 0;
      m_txb = 8'h00;
      m_cyc = 32'h0;
      m_ret = 32'h0;
    end else begin
      if (re) begin
        exp_val = 32'h0;
        if (addr == A_STATUS) exp_val = {30'b0, (m_rxq.size() != 0), (!m_txp && txr)};
        else if (addr == A_RX && m_rxq.size() != 0) exp_val = {24'b0, m_rxq[0]};
        else if (addr == A_CYC) exp_val = m_cyc;
        else if (addr == A_RET) exp_val = m_ret;
        exp_q.push_back(exp_val);
      end
      pop_ok  = re && (addr == A_RX) && (m_rxq.size() != 0);
      push_ok = rxv && (m_rxq.size() != RX_DEPTH);
      if (m_txp) begin
        if (txr) begin
          got = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
          checkOutput("tx_handshake", {24'b0, bus.uart_tx_data_in}, {24'b0, got});
          m_txp = 0;
        end
      end else if (we && addr == A_TX) begin
        m_txp = 1;
        m_txb = wd[7:0];
        tx_q.push_back(wd[7:0]);
      end
      if (pop_ok) void'(m_rxq.pop_front());
      if (push_ok) m_rxq.push_back(rxd);
      if (we && addr == A_CLR) begin
        m_cyc = 32'h0;
        m_ret = 32'h0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        m_ret = m_ret + {31'b0, retire};
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_rdata = 32'h0;
    end else if (re) begin
      if (exp_q.size() != 0) m_rdata = exp_q.pop_front();
    end
    model_valid = 1;
    checkOutput("rdata", bus.rdata, m_rdata);
  endtask

  task automatic idle(input bit retire);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, retire, 0, 8'h00, tx_rdy);
  endtask

  task automatic load(input logic [31:0] a);
    applyStimulus(0, 1, 0, a, 32'h0, 0, 0, 8'h00, tx_rdy);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(0, 0, 1, a, d, 0, 0, 8'h00, tx_rdy);
  endtask

  task automatic push(input logic [7:0] b);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 1, b, tx_rdy);
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1;
    bus.req_re = 0;
    bus.req_we = 0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.inst_retire = 0;
    bus.uart_rx_data_out_valid = 0;
    bus.uart_rx_data_out = '0;
    bus.uart_tx_data_in_ready = 1;

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 8'h00, 1);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_tx_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h0);
    checkOutput("rst_tx_byte", {24'b0, bus.uart_tx_data_in}, 32'h0);
    checkOutput("rst_rx_ready", {31'b0, bus.uart_rx_data_out_ready}, 32'h1);

    $display("[TB] counters from reset release");
    for (int i = 0; i < 100; i++) idle((i < 74) && (i % 2 == 0));
    load(A_CYC);
    checkOutput("cyc_100", bus.rdata, 32'd100);
    load(A_RET);
    checkOutput("ret_37", bus.rdata, 32'd37);
    applyStimulus(0, 0, 1, A_CLR, 32'hDEAD_BEEF, 1, 0, 8'h00, tx_rdy);
    load(A_CYC);
    checkOutput("cyc_clr", bus.rdata, 32'd0);
    load(A_RET);
    checkOutput("ret_clr", bus.rdata, 32'd0);

    $display("[TB] rx basic");
    push(8'h41);
    push(8'h42);
    load(A_STATUS);
    checkOutput("status_rx", bus.rdata, 32'h3);
    load(A_RX);
    checkOutput("rx_41", bus.rdata, 32'h41);
    load(A_RX);
    checkOutput("rx_42", bus.rdata, 32'h42);
    load(A_STATUS);
    checkOutput("status_empty", bus.rdata, 32'h1);

    $display("[TB] rx overflow and wrap");
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    checkOutput("rx_full_ready", {31'b0, bus.uart_rx_data_out_ready}, 32'h0);
    push(8'h14);
    for (int i = 0; i < 4; i++) begin
      load(A_RX);
      checkOutput("rx_drain", bus.rdata, 32'h10 + 32'(i));
    end
    load(A_RX);
    checkOutput("rx_empty", bus.rdata, 32'h0);
    push(8'h20);
    applyStimulus(0, 1, 0, A_RX, 32'h0, 0, 1, 8'h21, tx_rdy);
    checkOutput("rx_pushpop", bus.rdata, 32'h20);
    load(A_RX);
    checkOutput("rx_after_pp", bus.rdata, 32'h21);

    $display("[TB] tx backpressure");
    tx_rdy = 0;
    store(A_TX, 32'hFFFF_FF55);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      checkOutput("tx_hold_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h1);
      checkOutput("tx_hold_byte", {24'b0, bus.uart_tx_data_in}, 32'h55);
    end
    store(A_TX, 32'h66);
    checkOutput("tx_drop", {24'b0, bus.uart_tx_data_in}, 32'h55);
    load(A_STATUS);
    checkOutput("status_busy", bus.rdata, 32'h0);
    tx_rdy = 1;
    idle(0);
    checkOutput("tx_done_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h0);
    load(A_STATUS);
    checkOutput("status_txrdy", bus.rdata, 32'h1);

    $display("[TB] unmapped");
    store(32'h0000_0008, 32'h77);
    load(A_TX);
    checkOutput("load_wo_tx", bus.rdata, 32'h0);
    load(BASE + 32'h0C);
    checkOutput("load_hole", bus.rdata, 32'h0);
    load(32'h0000_0010);
    checkOutput("load_low", bus.rdata, 32'h0);

    $display("[TB] cycle counter wrap");
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cyc = 32'hFFFF_FFFF;
    load(A_CYC);
    checkOutput("cyc_max", bus.rdata, 32'hFFFF_FFFF);
    load(A_CYC);
    checkOutput("cyc_wrap", bus.rdata, 32'h0);

    $display("[TB] reset mid-transfer");
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    tx_rdy = 0;
    store(A_TX, 32'h99);
    applyStimulus(1, 1, 0, A_RX, 32'h0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 1, A_TX, 32'h77, 1, 1, 8'hEE, 0);
    checkOutput("rst2_rx_ready", {31'b0, bus.uart_rx_data_out_ready}, 32'h1);
    checkOutput("rst2_tx_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'h0);
    checkOutput("rst2_tx_byte", {24'b0, bus.uart_tx_data_in}, 32'h0);
    tx_rdy = 1;
    load(A_STATUS);
    checkOutput("rst2_status", bus.rdata, 32'h1);
    load(A_RX);
    checkOutput("rst2_rx", bus.rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
